// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/MEM requesters, the port arbiter and the memory bridge.
// The arbiter uses the slave view; the surrounding pipeline/memory use the master view.
interface mem_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one handshake memory port between fetch and load/store,
// with an in-order source-ID FIFO that routes each response back to its issuer.
module mem_port_arbiter #(
  parameter int DEPTH = 2
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic SRC_DATA = 1'b1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] src_q, src_d;
  logic             last_q, last_d;
  logic             lock_q, lock_d;
  logic             lock_src_q, lock_src_d;

  logic sel, any_req, full, mem_req, push, pop, head;

  // Power-of-two depth lets pointers wrap on overflow; a single entry never moves.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (DEPTH == 1) return '0;
    return p + PW'(1);
  endfunction

  always_comb begin
    any_req = bus.inst_req | bus.data_req;
    if (lock_q)                          sel = lock_src_q;
    else if (bus.inst_req & bus.data_req) sel = ~last_q;
    else                                 sel = bus.data_req;
    full    = (cnt_q == CW'(DEPTH));
    mem_req = any_req & ~full;
    push    = mem_req & bus.mem_addr_ok;
    pop     = bus.mem_data_ok & (cnt_q != '0);
    head    = src_q[rd_ptr_q];
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_wr    = sel ? bus.data_wr    : 1'b0;
  assign bus.mem_size  = sel ? bus.data_size  : 2'd2;
  assign bus.mem_wstrb = sel ? bus.data_wstrb : 4'h0;
  assign bus.mem_addr  = sel ? bus.data_addr  : bus.inst_addr;
  assign bus.mem_wdata = sel ? bus.data_wdata : 32'h0;

  assign bus.inst_addr_ok = push & ~sel;
  assign bus.data_addr_ok = push &  sel;
  assign bus.inst_data_ok = pop  & ~head;
  assign bus.data_data_ok = pop  &  head;
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  always_comb begin
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    src_d      = src_q;
    last_d     = last_q;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (push) begin
      src_d[wr_ptr_q] = sel;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
      last_d          = sel;
      lock_d          = 1'b0;
    end else if (mem_req) begin
      // Presented but not taken: pin the choice until the memory accepts it.
      lock_d     = 1'b1;
      lock_src_d = sel;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lock_q   <= 1'b0;
      last_q   <= SRC_DATA;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lock_q   <= lock_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    src_q      <= src_d;
    lock_src_q <= lock_src_d;
  end
endmodule
